alu: RTL and testbench

Three-operation chained ALU. Four 8-bit operands and three 3-bit opcodes are combined left to right: ((A op2 B) op1 C) op0 D. The result is a 16-bit value. The datapath is a 3-stage pipeline, one operation per stage. It accepts a new operand/opcode set every clock and sits as a standalone arithmetic block driven directly by its parent.

---
 rtl/alu.sv | 103 ++++++++++
 tb/tb_alu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Three-stage chained ALU: OUT = ((A op2 B) op1 C) op0 D.
// One operation per pipeline stage. A new operand/opcode set is accepted every cycle.
module alu (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [8:0]  OPCODES,
    input  logic [31:0] OPRANDS,
    output logic [15:0] OUT
);

    // Opcode encoding shared by all three stages.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_t;

    // Stage 1 output: first partial result, plus the operands and opcodes
    // that the later stages still need.
    typedef struct packed {
        logic [15:0] r;
        logic [7:0]  c;
        logic [7:0]  d;
        op_t         op1;
        op_t         op0;
    } s1_t;

    // Stage 2 output: second partial result, plus what stage 3 needs.
    typedef struct packed {
        logic [15:0] r;
        logic [7:0]  d;
        op_t         op0;
    } s2_t;

    // One ALU operation. The 8-bit operand is zero-extended to 16 bits.
    // Every result is truncated to 16 bits, and shifts use only y[3:0].
    function automatic logic [15:0] apply_op(input op_t op, input logic [15:0] x,
                                             input logic [7:0] y);
        logic [15:0] yz;
        logic [15:0] res;
        yz = {8'h00, y};
        case (op)
            OP_ADD: res = x + yz;
            OP_SUB: res = x - yz;
            OP_MUL: res = x * yz;
            OP_AND: res = x & yz;
            OP_OR:  res = x | yz;
            OP_XOR: res = x ^ yz;
            OP_SHL: res = x << y[3:0];
            OP_SHR: res = x >> y[3:0];
        endcase
        return res;
    endfunction

    s1_t s1_q;
    s2_t s2_q;

    logic [7:0] opr_a, opr_b, opr_c, opr_d;
    assign opr_a = OPRANDS[31:24];
    assign opr_b = OPRANDS[23:16];
    assign opr_c = OPRANDS[15:8];
    assign opr_d = OPRANDS[7:0];

    // Stage 1: A op2 B, capturing C, D, op1 and op0 alongside the result.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q <= '0;
        end else begin
            s1_q.r   <= apply_op(op_t'(OPCODES[8:6]), {8'h00, opr_a}, opr_b);
            s1_q.c   <= opr_c;
            s1_q.d   <= opr_d;
            s1_q.op1 <= op_t'(OPCODES[5:3]);
            s1_q.op0 <= op_t'(OPCODES[2:0]);
        end
    end

    // Stage 2: R1 op1 C, carrying D and op0 forward.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_q <= '0;
        end else begin
            s2_q.r   <= apply_op(s1_q.op1, s1_q.r, s1_q.c);
            s2_q.d   <= s1_q.d;
            s2_q.op0 <= s1_q.op0;
        end
    end

    // Stage 3: registered final result R2 op0 D.
    // A zeroed pipeline evaluates 0 ADD 0, so OUT stays 0 after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT <= '0;
        end else begin
            OUT <= apply_op(s2_q.op0, s2_q.r, s2_q.d);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu. It uses directed test-plan vectors and then
// randomized traffic, and checks every cycle against a behavioural model.
module tb_alu;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [8:0]  OPCODES = '0;
    logic [31:0] OPRANDS = '0;
    logic [15:0] OUT;

    int tests = 0;
    int fails = 0;

    // The model keeps the results of the last three sampled input sets.
    // exp_q[0] is the value OUT must show after the most recent edge.
    int exp_q[$] = '{0, 0, 0};

    alu dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .OPCODES (OPCODES),
        .OPRANDS (OPRANDS),
        .OUT     (OUT)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // One operation in plain integer arithmetic, masked to 16 bits.
    function automatic int op_ref(input int op, input int x, input int y);
        case (op)
            0: return (x + y) & 32'hFFFF;
            1: return (x - y) & 32'hFFFF;
            2: return (x * y) & 32'hFFFF;
            3: return x & y;
            4: return x | y;
            5: return x ^ y;
            6: return (x << (y % 16)) & 32'hFFFF;
            default: return x >> (y % 16);
        endcase
    endfunction

    // Full chain ((A op2 B) op1 C) op0 D.
    function automatic int chain_ref(input logic [8:0] ops, input logic [31:0] v);
        int r;
        r = int'(v[31:24]);
        r = op_ref(int'(ops[8:6]), r, int'(v[23:16]));
        r = op_ref(int'(ops[5:3]), r, int'(v[15:8]));
        r = op_ref(int'(ops[2:0]), r, int'(v[7:0]));
        return r;
    endfunction

    // Model: reset flushes all in-flight results.
    // Each edge queues the result of the inputs sampled at that edge.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_q = '{0, 0, 0};
        end else begin
            exp_q.push_back(chain_ref(OPCODES, OPRANDS));
            void'(exp_q.pop_front());
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %04h expected %04h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one clock and compare OUT against the model, away from the edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        check("model", int'(OUT), exp_q[0]);
    endtask

    task automatic drive(input logic [8:0] ops, input logic [31:0] opr);
        OPCODES = ops;
        OPRANDS = opr;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        check("reset_out", int'(OUT), 0);
        RST_N = 1'b1;
    endtask

    // Reset, apply one set, then check OUT is 0 after edges 1-2 and equals exp after edge 3.
    task automatic directed(input string name, input logic [8:0] ops,
                            input logic [31:0] opr, input int exp);
        do_reset();
        drive(ops, opr);
        step();
        check({name, "_e1"}, int'(OUT), 0);
        step();
        check({name, "_e2"}, int'(OUT), 0);
        step();
        check(name, int'(OUT), exp);
        check({name, "_model"}, exp_q[0], exp);
    endtask

    initial begin
        @(negedge CLK);
        check("reset_out0", int'(OUT), 0);
        RST_N = 1'b1;

        directed("basic",  9'b000_010_100, 32'h0C_06_02_04, 16'h0024);
        directed("sub_wr", 9'b001_000_000, 32'h01_02_00_00, 16'hFFFF);
        directed("mul_tr", 9'b010_010_000, 32'hFF_FF_FF_00, 16'h02FF);
        directed("shift",  9'b110_111_101, 32'h01_0F_04_FF, 16'h08FF);
        directed("shl16",  9'b110_000_000, 32'h01_10_00_00, 16'h0001);
        directed("andxor", 9'b011_101_000, 32'hF0_3C_FF_01, 16'h00D0);

        // Back-to-back sets must produce results on consecutive cycles.
        do_reset();
        drive(9'b000_010_100, 32'h0C_06_02_04);
        step();
        drive(9'b011_101_000, 32'hF0_3C_FF_01);
        step();
        step();
        check("b2b_first", int'(OUT), 16'h0024);
        step();
        check("b2b_second", int'(OUT), 16'h00D0);

        // Async reset mid-flight: OUT holds 0xD0 and the basic chain is in stage 1.
        drive(9'b000_010_100, 32'h0C_06_02_04);
        step();
        check("pre_rst", int'(OUT), 16'h00D0);
        #2 RST_N = 1'b0;
        #1 check("async_rst", int'(OUT), 0);
        step();
        RST_N = 1'b1;
        drive(9'b110_111_101, 32'h01_0F_04_FF);
        step();
        check("flush_e1", int'(OUT), 0);
        step();
        check("flush_e2", int'(OUT), 0);
        step();
        check("flush_e3", int'(OUT), 16'h08FF);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] opr;
            opr = $urandom;
            if ($urandom_range(0, 3) == 0) opr[23:16] = 8'($urandom_range(0, 20));
            drive(9'($urandom_range(0, 511)), opr);
            if (i == 200) begin
                #2 RST_N = 1'b0;
                #1 check("rnd_async_rst", int'(OUT), 0);
                step();
                RST_N = 1'b1;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
